csr_regfile: RTL and testbench
==============================

Name: csr_regfile

Overview:
- Machine-mode CSR register file; the storage end of the CSR access path.
- Accepts the write enable, address and fully merged write data produced by the CSR write-data logic (csrrw/rs/rc and immediate forms).
- Returns the current CSR value combinationally, so the merge can be computed in the same cycle.
- Owns the cycle/instret counters and the trap-entry and mret side effects on mstatus/mepc/mcause/mtval.

Parameters:
- DATA_WIDTH, 32, CSR data width; only 32 is supported.
- CSR_ADDR_WIDTH, 12, CSR address width.
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec.
- MISA_VALUE, 32'h4000_0100, read-only misa value (RV32I).

Ports:
- clk  input  1  core clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- csr_addr_i  input  CSR_ADDR_WIDTH  CSR address, shared by read and write.
- csr_we_i  input  1  write strobe for csr_addr_i.
- csr_wdata_i  input  DATA_WIDTH  merged write data.
- csr_rdata_o  output  DATA_WIDTH  combinational read of csr_addr_i.
- csr_illegal_o  output  1  combinational; access to an unimplemented CSR, or a write to a read-only CSR.
- instret_i  input  1  one instruction retired this cycle.
- trap_valid_i  input  1  trap entry this cycle.
- trap_pc_i  input  DATA_WIDTH  PC of the trapping instruction.
- trap_cause_i  input  DATA_WIDTH  mcause value.
- trap_val_i  input  DATA_WIDTH  mtval value.
- mret_i  input  1  mret executing this cycle.
- mtvec_o  output  DATA_WIDTH  current mtvec.
- mepc_o  output  DATA_WIDTH  current mepc.
- mie_global_o  output  1  mstatus.MIE.

Behaviour:
- **Address map**
  - mstatus 0x300: only MIE[3] and MPIE[7] are stored; MPP[12:11] reads 2'b11; all other bits read 0.
  - misa 0x301: read-only, returns MISA_VALUE.
  - mie 0x304, mtvec 0x305, mscratch 0x340: full 32-bit read/write.
  - mepc 0x341: bits[1:0] are forced to 0 on every write.
  - mcause 0x342, mtval 0x343: full 32-bit read/write.
  - mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82: read/write halves of the 64-bit counters.
  - cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82: read-only aliases of the counters.
  - mhartid 0xF14: reads 0.
- **Reads**
  - Purely combinational from current register state; no write bypass.
  - A write in cycle N is visible on csr_rdata_o from cycle N+1.
  - An unimplemented address reads 0.
- **csr_illegal_o** is high when either:
  - csr_addr_i is not in the map (regardless of csr_we_i), or
  - csr_we_i=1 and csr_addr_i[11:10]==2'b11.
- **Ignored writes:** writes to read-only or unimplemented addresses leave all state unchanged.
- **Counters**
  - The 64-bit cycle counter increments by 1 every clock.
  - The 64-bit instret counter increments by 1 when instret_i=1.
  - Both wrap from all-ones to 0 with no flag.
  - A software write to one half in the same cycle wins over the increment for the entire counter that cycle: the written half takes csr_wdata_i, the other half holds its value, and there is no increment.
- **Trap entry** (trap_valid_i=1), registered at the edge:
  - mepc <= trap_pc_i with bits[1:0] cleared.
  - mcause <= trap_cause_i.
  - mtval <= trap_val_i.
  - MPIE <= MIE.
  - MIE <= 0.
- **mret:** MIE <= MPIE and MPIE <= 1.
- **Priority**
  - For mstatus, mepc, mcause and mtval: trap_valid_i > mret_i > csr_we_i.
  - A software write to one of these registers in the same cycle as a trap is dropped.
  - A software write to any other register in the same cycle as a trap or mret proceeds normally.
- **Outputs**
  - mtvec_o, mepc_o and mie_global_o are direct register outputs.
  - They update one cycle after the causing edge.
- **Reset** (asynchronous assert, synchronous deassert is handled upstream):
  - mtvec = MTVEC_RESET.
  - mstatus MIE=0, MPIE=0.
  - mie, mscratch, mepc, mcause, mtval = 0.
  - Both counters = 0.
  - Reset mid-operation discards any pending write; the first increment occurs at the first rising edge with rst_n=1.

Test Plan:
- Reset, then read 0x305 and 0xB00 on the first edge after release → 32'h0 and 32'h0; mhartid 0xF14 reads 0; misa 0x301 reads 32'h4000_0100.
- Write mscratch 0x340 = 32'hDEAD_BEEF → csr_rdata_o still shows the old value in the write cycle and 32'hDEAD_BEEF from the next cycle; write mepc = 32'h0000_1003 → reads 32'h0000_1000.
- Write mcycle 0xB00 = 32'hFFFF_FFFF with mcycleh = 0 → one cycle later mcycleh=1, mcycle=0; write cycle 0xC00 → csr_illegal_o=1 and the value is unchanged.
- Set MIE (write mstatus 32'h8), then trap_valid_i with pc 32'h0000_0206, cause 32'h8000_0007 → mepc=32'h204, mcause=32'h8000_0007, MIE=0, MPIE=1, mstatus reads 32'h1880; mret → MIE=1, MPIE=1, mstatus reads 32'h1888.
- trap_valid_i, mret_i and a csr_we_i to mepc = 32'h40 in the same cycle → mepc = trap PC and MIE=0; a simultaneous write to mscratch = 32'h5 does take effect.
- Pulse rst_n low mid-stream with csr_we_i=1 to mtvec = 32'h100 → mtvec = MTVEC_RESET immediately, without waiting for a clock edge; counters restart from 0.

Source files
------------

// File: rtl/csr_regfile.sv
// Machine-mode CSR storage: combinational read port, merged-data write port,
// 64-bit cycle/instret counters and trap/mret side effects on mstatus/mepc/mcause/mtval.
module csr_regfile #(
    parameter int                DATA_WIDTH     = 32,
    parameter int                CSR_ADDR_WIDTH = 12,
    parameter logic [31:0]       MTVEC_RESET    = 32'h0000_0000,
    parameter logic [31:0]       MISA_VALUE     = 32'h4000_0100
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CSR_ADDR_WIDTH-1:0] csr_addr_i,
    input  logic                      csr_we_i,
    input  logic [DATA_WIDTH-1:0]     csr_wdata_i,
    output logic [DATA_WIDTH-1:0]     csr_rdata_o,
    output logic                      csr_illegal_o,
    input  logic                      instret_i,
    input  logic                      trap_valid_i,
    input  logic [DATA_WIDTH-1:0]     trap_pc_i,
    input  logic [DATA_WIDTH-1:0]     trap_cause_i,
    input  logic [DATA_WIDTH-1:0]     trap_val_i,
    input  logic                      mret_i,
    output logic [DATA_WIDTH-1:0]     mtvec_o,
    output logic [DATA_WIDTH-1:0]     mepc_o,
    output logic                      mie_global_o
);

    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MSTATUS   = 'h300;
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MISA      = 'h301;
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MIE       = 'h304;
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MTVEC     = 'h305;
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MSCRATCH  = 'h340;
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MEPC      = 'h341;
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MCAUSE    = 'h342;
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MTVAL     = 'h343;
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MCYCLE    = 'hB00;
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MINSTRET  = 'hB02;
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MCYCLEH   = 'hB80;
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MINSTRETH = 'hB82;
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_CYCLE     = 'hC00;
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_INSTRET   = 'hC02;
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_CYCLEH    = 'hC80;
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_INSTRETH  = 'hC82;
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MHARTID   = 'hF14;

    logic                  mstatus_mie_reg;
    logic                  mstatus_mpie_reg;
    logic [DATA_WIDTH-1:0] mie_reg;
    logic [DATA_WIDTH-1:0] mtvec_reg;
    logic [DATA_WIDTH-1:0] mscratch_reg;
    logic [DATA_WIDTH-1:0] mepc_reg;
    logic [DATA_WIDTH-1:0] mcause_reg;
    logic [DATA_WIDTH-1:0] mtval_reg;
    logic [1:0][2*DATA_WIDTH-1:0] count;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  addr_hit;
    logic                  wr_en;
    logic [1:0]            count_inc;

    // The 0xC00-0xFFF range is read-only, so writes there never reach state.
    assign wr_en     = csr_we_i && (csr_addr_i[11:10] != 2'b11);
    assign count_inc = {instret_i, 1'b1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_counter
            localparam logic [CSR_ADDR_WIDTH-1:0] LO_ADDR = (gi == 0) ? ADDR_MCYCLE  : ADDR_MINSTRET;
            localparam logic [CSR_ADDR_WIDTH-1:0] HI_ADDR = (gi == 0) ? ADDR_MCYCLEH : ADDR_MINSTRETH;
            logic [2*DATA_WIDTH-1:0] count_reg;

            // A software write to either half suppresses the increment for the whole counter.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_reg <= '0;
                end else if (wr_en && csr_addr_i == LO_ADDR) begin
                    count_reg[DATA_WIDTH-1:0] <= csr_wdata_i;
                end else if (wr_en && csr_addr_i == HI_ADDR) begin
                    count_reg[2*DATA_WIDTH-1:DATA_WIDTH] <= csr_wdata_i;
                end else if (count_inc[gi]) begin
                    count_reg <= count_reg + 1'b1;
                end
            end

            assign count[gi] = count_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie_reg  <= 1'b0;
            mstatus_mpie_reg <= 1'b0;
            mie_reg          <= '0;
            mtvec_reg        <= MTVEC_RESET;
            mscratch_reg     <= '0;
            mepc_reg         <= '0;
            mcause_reg       <= '0;
            mtval_reg        <= '0;
        end else begin
            if (trap_valid_i) begin
                mstatus_mpie_reg <= mstatus_mie_reg;
                mstatus_mie_reg  <= 1'b0;
            end else if (mret_i) begin
                mstatus_mie_reg  <= mstatus_mpie_reg;
                mstatus_mpie_reg <= 1'b1;
            end else if (wr_en && csr_addr_i == ADDR_MSTATUS) begin
                mstatus_mie_reg  <= csr_wdata_i[3];
                mstatus_mpie_reg <= csr_wdata_i[7];
            end

            if (trap_valid_i) begin
                mepc_reg   <= {trap_pc_i[DATA_WIDTH-1:2], 2'b00};
                mcause_reg <= trap_cause_i;
                mtval_reg  <= trap_val_i;
            end else if (wr_en) begin
                if (csr_addr_i == ADDR_MEPC)   mepc_reg   <= {csr_wdata_i[DATA_WIDTH-1:2], 2'b00};
                if (csr_addr_i == ADDR_MCAUSE) mcause_reg <= csr_wdata_i;
                if (csr_addr_i == ADDR_MTVAL)  mtval_reg  <= csr_wdata_i;
            end

            if (wr_en && csr_addr_i == ADDR_MIE)      mie_reg      <= csr_wdata_i;
            if (wr_en && csr_addr_i == ADDR_MTVEC)    mtvec_reg    <= csr_wdata_i;
            if (wr_en && csr_addr_i == ADDR_MSCRATCH) mscratch_reg <= csr_wdata_i;
        end
    end

    always_comb begin
        rdata    = '0;
        addr_hit = 1'b1;
        case (csr_addr_i)
            ADDR_MSTATUS:               rdata = {19'b0, 2'b11, 3'b0, mstatus_mpie_reg, 3'b0, mstatus_mie_reg, 3'b0};
            ADDR_MISA:                  rdata = MISA_VALUE;
            ADDR_MIE:                   rdata = mie_reg;
            ADDR_MTVEC:                 rdata = mtvec_reg;
            ADDR_MSCRATCH:              rdata = mscratch_reg;
            ADDR_MEPC:                  rdata = mepc_reg;
            ADDR_MCAUSE:                rdata = mcause_reg;
            ADDR_MTVAL:                 rdata = mtval_reg;
            ADDR_MCYCLE,   ADDR_CYCLE:    rdata = count[0][DATA_WIDTH-1:0];
            ADDR_MCYCLEH,  ADDR_CYCLEH:   rdata = count[0][2*DATA_WIDTH-1:DATA_WIDTH];
            ADDR_MINSTRET, ADDR_INSTRET:  rdata = count[1][DATA_WIDTH-1:0];
            ADDR_MINSTRETH, ADDR_INSTRETH: rdata = count[1][2*DATA_WIDTH-1:DATA_WIDTH];
            ADDR_MHARTID:               rdata = '0;
            default:                    addr_hit = 1'b0;
        endcase
    end

    assign csr_rdata_o   = rdata;
    assign csr_illegal_o = !addr_hit || (csr_we_i && csr_addr_i[11:10] == 2'b11);
    assign mtvec_o       = mtvec_reg;
    assign mepc_o        = mepc_reg;
    assign mie_global_o  = mstatus_mie_reg;

endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile: reset, read/write, counters, trap/mret, priority, async reset.
module tb_csr_regfile;

    logic        clk;
    logic        rst_n;
    logic [11:0] csr_addr;
    logic        csr_we;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        instret;
    logic        trap_valid;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic [31:0] trap_val;
    logic        mret;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        mie_global;

    int checks   = 0;
    int failures = 0;

    csr_regfile dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .csr_addr_i    (csr_addr),
        .csr_we_i      (csr_we),
        .csr_wdata_i   (csr_wdata),
        .csr_rdata_o   (csr_rdata),
        .csr_illegal_o (csr_illegal),
        .instret_i     (instret),
        .trap_valid_i  (trap_valid),
        .trap_pc_i     (trap_pc),
        .trap_cause_i  (trap_cause),
        .trap_val_i    (trap_val),
        .mret_i        (mret),
        .mtvec_o       (mtvec),
        .mepc_o        (mepc),
        .mie_global_o  (mie_global)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Read the combinational port after settling; no clock edge is crossed.
    task automatic peek(input logic [11:0] addr);
        csr_addr = addr;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        peek(12'h305);
        checks++; if (csr_rdata !== 32'h0) begin failures++; $display("FAIL reset_mtvec_read got=%h exp=%h", csr_rdata, 32'h0); end
        checks++; if (mtvec !== 32'h0 || mepc !== 32'h0 || mie_global !== 1'b0) begin failures++; $display("FAIL reset_outputs got=%h/%h/%b exp=0/0/0", mtvec, mepc, mie_global); end
        peek(12'hB00);
        checks++; if (csr_rdata !== 32'h0) begin failures++; $display("FAIL reset_mcycle got=%h exp=%h", csr_rdata, 32'h0); end
        peek(12'hF14);
        checks++; if (csr_rdata !== 32'h0 || csr_illegal !== 1'b0) begin failures++; $display("FAIL mhartid got=%h ill=%b exp=0 ill=0", csr_rdata, csr_illegal); end
        peek(12'h301);
        checks++; if (csr_rdata !== 32'h4000_0100) begin failures++; $display("FAIL misa got=%h exp=%h", csr_rdata, 32'h4000_0100); end
        peek(12'h300);
        checks++; if (csr_rdata !== 32'h0000_1800) begin failures++; $display("FAIL reset_mstatus got=%h exp=%h", csr_rdata, 32'h0000_1800); end
        peek(12'h123);
        checks++; if (csr_rdata !== 32'h0 || csr_illegal !== 1'b1) begin failures++; $display("FAIL unmapped_read got=%h ill=%b exp=0 ill=1", csr_rdata, csr_illegal); end
        csr_addr = 12'hB00;
        tick;
        checks++; if (csr_rdata !== 32'h1) begin failures++; $display("FAIL first_increment got=%h exp=%h", csr_rdata, 32'h1); end
        $display("test_reset done");
    endtask

    task automatic test_rw;
        csr_addr = 12'h340; csr_wdata = 32'hDEAD_BEEF; csr_we = 1'b1;
        #1;
        checks++; if (csr_rdata !== 32'h0) begin failures++; $display("FAIL mscratch_no_bypass got=%h exp=%h", csr_rdata, 32'h0); end
        tick; csr_we = 1'b0; #1;
        checks++; if (csr_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mscratch_write got=%h exp=%h", csr_rdata, 32'hDEAD_BEEF); end
        csr_addr = 12'h341; csr_wdata = 32'h0000_1003; csr_we = 1'b1;
        tick; csr_we = 1'b0; #1;
        checks++; if (csr_rdata !== 32'h0000_1000 || mepc !== 32'h0000_1000) begin failures++; $display("FAIL mepc_align got=%h out=%h exp=%h", csr_rdata, mepc, 32'h0000_1000); end
        csr_addr = 12'h305; csr_wdata = 32'h0000_0080; csr_we = 1'b1;
        tick; csr_we = 1'b0; #1;
        checks++; if (mtvec !== 32'h0000_0080 || csr_rdata !== 32'h0000_0080) begin failures++; $display("FAIL mtvec_write got=%h out=%h exp=%h", csr_rdata, mtvec, 32'h80); end
        csr_addr = 12'h304; csr_wdata = 32'h0000_0888; csr_we = 1'b1;
        tick; csr_we = 1'b0; #1;
        checks++; if (csr_rdata !== 32'h0000_0888) begin failures++; $display("FAIL mie_write got=%h exp=%h", csr_rdata, 32'h888); end
        $display("test_rw done");
    endtask

    task automatic test_counters;
        csr_addr = 12'hB80; csr_wdata = 32'h0; csr_we = 1'b1;
        tick;
        csr_addr = 12'hB00; csr_wdata = 32'hFFFF_FFFF;
        tick; csr_we = 1'b0; #1;
        checks++; if (csr_rdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mcycle_write got=%h exp=%h", csr_rdata, 32'hFFFF_FFFF); end
        tick;
        checks++; if (csr_rdata !== 32'h0) begin failures++; $display("FAIL mcycle_carry_lo got=%h exp=%h", csr_rdata, 32'h0); end
        peek(12'hB80);
        checks++; if (csr_rdata !== 32'h1) begin failures++; $display("FAIL mcycle_carry_hi got=%h exp=%h", csr_rdata, 32'h1); end
        peek(12'hC80);
        checks++; if (csr_rdata !== 32'h1 || csr_illegal !== 1'b0) begin failures++; $display("FAIL cycleh_alias got=%h ill=%b exp=1 ill=0", csr_rdata, csr_illegal); end
        csr_addr = 12'hC00; csr_wdata = 32'h0000_1234; csr_we = 1'b1;
        #1;
        checks++; if (csr_illegal !== 1'b1) begin failures++; $display("FAIL cycle_write_illegal got=%b exp=1", csr_illegal); end
        tick; csr_we = 1'b0; #1;
        checks++; if (csr_rdata !== 32'h1) begin failures++; $display("FAIL cycle_write_ignored got=%h exp=%h", csr_rdata, 32'h1); end
        // Full 64-bit wrap
        csr_addr = 12'hB80; csr_wdata = 32'hFFFF_FFFF; csr_we = 1'b1;
        tick;
        csr_addr = 12'hB00;
        tick; csr_we = 1'b0;
        tick;
        checks++; if (csr_rdata !== 32'h0) begin failures++; $display("FAIL wrap_lo got=%h exp=%h", csr_rdata, 32'h0); end
        peek(12'hB80);
        checks++; if (csr_rdata !== 32'h0) begin failures++; $display("FAIL wrap_hi got=%h exp=%h", csr_rdata, 32'h0); end
        // instret: write wins over a retire in the same cycle
        csr_addr = 12'hB02; csr_wdata = 32'h5; csr_we = 1'b1; instret = 1'b1;
        tick; csr_we = 1'b0; #1;
        checks++; if (csr_rdata !== 32'h5) begin failures++; $display("FAIL minstret_write_wins got=%h exp=%h", csr_rdata, 32'h5); end
        tick; instret = 1'b0;
        checks++; if (csr_rdata !== 32'h6) begin failures++; $display("FAIL minstret_inc got=%h exp=%h", csr_rdata, 32'h6); end
        tick;
        peek(12'hC02);
        checks++; if (csr_rdata !== 32'h6) begin failures++; $display("FAIL instret_hold got=%h exp=%h", csr_rdata, 32'h6); end
        $display("test_counters done");
    endtask

    task automatic test_trap;
        csr_addr = 12'h300; csr_wdata = 32'h0000_0008; csr_we = 1'b1;
        tick; csr_we = 1'b0; #1;
        checks++; if (csr_rdata !== 32'h0000_1808 || mie_global !== 1'b1) begin failures++; $display("FAIL mstatus_set_mie got=%h mie=%b exp=%h mie=1", csr_rdata, mie_global, 32'h1808); end
        trap_valid = 1'b1; trap_pc = 32'h0000_0206; trap_cause = 32'h8000_0007; trap_val = 32'h0000_0055;
        tick; trap_valid = 1'b0; #1;
        checks++; if (mepc !== 32'h0000_0204) begin failures++; $display("FAIL trap_mepc got=%h exp=%h", mepc, 32'h204); end
        checks++; if (csr_rdata !== 32'h0000_1880 || mie_global !== 1'b0) begin failures++; $display("FAIL trap_mstatus got=%h mie=%b exp=%h mie=0", csr_rdata, mie_global, 32'h1880); end
        peek(12'h342);
        checks++; if (csr_rdata !== 32'h8000_0007) begin failures++; $display("FAIL trap_mcause got=%h exp=%h", csr_rdata, 32'h8000_0007); end
        peek(12'h343);
        checks++; if (csr_rdata !== 32'h0000_0055) begin failures++; $display("FAIL trap_mtval got=%h exp=%h", csr_rdata, 32'h55); end
        csr_addr = 12'h300; mret = 1'b1;
        tick; mret = 1'b0; #1;
        checks++; if (csr_rdata !== 32'h0000_1888 || mie_global !== 1'b1) begin failures++; $display("FAIL mret_mstatus got=%h mie=%b exp=%h mie=1", csr_rdata, mie_global, 32'h1888); end
        $display("test_trap done");
    endtask

    task automatic test_priority;
        trap_valid = 1'b1; mret = 1'b1; trap_pc = 32'h0000_0300; trap_cause = 32'h0000_0002; trap_val = 32'h0;
        csr_addr = 12'h341; csr_wdata = 32'h0000_0040; csr_we = 1'b1;
        tick; trap_valid = 1'b0; mret = 1'b0; csr_we = 1'b0; #1;
        checks++; if (mepc !== 32'h0000_0300) begin failures++; $display("FAIL prio_mepc got=%h exp=%h", mepc, 32'h300); end
        checks++; if (mie_global !== 1'b0) begin failures++; $display("FAIL prio_mie got=%b exp=0", mie_global); end
        trap_valid = 1'b1; trap_pc = 32'h0000_0400; trap_cause = 32'h0000_000B; trap_val = 32'h0000_0077;
        csr_addr = 12'h340; csr_wdata = 32'h0000_0005; csr_we = 1'b1;
        tick; trap_valid = 1'b0; csr_we = 1'b0; #1;
        checks++; if (csr_rdata !== 32'h0000_0005) begin failures++; $display("FAIL prio_mscratch got=%h exp=%h", csr_rdata, 32'h5); end
        peek(12'h342);
        checks++; if (csr_rdata !== 32'h0000_000B || mepc !== 32'h0000_0400) begin failures++; $display("FAIL prio_second_trap got=%h mepc=%h exp=b mepc=400", csr_rdata, mepc); end
        $display("test_priority done");
    endtask

    task automatic test_async_reset;
        csr_addr = 12'h305; csr_wdata = 32'h0000_0100; csr_we = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (mtvec !== 32'h0) begin failures++; $display("FAIL async_mtvec got=%h exp=%h", mtvec, 32'h0); end
        peek(12'hB00);
        checks++; if (csr_rdata !== 32'h0) begin failures++; $display("FAIL async_counter got=%h exp=%h", csr_rdata, 32'h0); end
        csr_addr = 12'h305;
        tick;
        csr_we = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++; if (mtvec !== 32'h0) begin failures++; $display("FAIL reset_drops_write got=%h exp=%h", mtvec, 32'h0); end
        peek(12'hB00);
        tick;
        checks++; if (csr_rdata !== 32'h1) begin failures++; $display("FAIL restart_count got=%h exp=%h", csr_rdata, 32'h1); end
        $display("test_async_reset done");
    endtask

    initial begin
        rst_n = 1'b0; csr_addr = '0; csr_we = 1'b0; csr_wdata = '0; instret = 1'b0;
        trap_valid = 1'b0; trap_pc = '0; trap_cause = '0; trap_val = '0; mret = 1'b0;
        test_reset;
        test_rw;
        test_counters;
        test_trap;
        test_priority;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
